normalize_64: RTL and testbench
===============================

# normalize_64

Two-stage pipelined left-normalizer that sits directly downstream of `count_leading_zeros_64`. It accepts a 64-bit word together with that word's leading-zero count and shifts the word so its MSB is 1. It outputs the normalized word, an unbiased exponent (bit index of the original MSB) and zero/error flags. The block also cross-checks the upstream count: any count that fails to normalize the word is flagged rather than silently passed on.

## Interface
- Parameters: none; datapath width fixed at 64, count width fixed at 7.
- i_CLK  input  1  clock; all state updates on rising edge.
- i_RST  input  1  synchronous, active-high reset.
- i_WORD  input  64  word to normalize.
- i_LZC  input  7  leading-zero count of i_WORD from `count_leading_zeros_64`; legal range 0..64.
- i_VALID  input  1  i_WORD/i_LZC valid this cycle.
- o_READY  output  1  block accepts input this cycle.
- o_NORM  output  64  i_WORD << i_LZC (zero-filled).
- o_EXP  output  7  63 - i_LZC for nonzero words; 0 when o_ZERO.
- o_ZERO  output  1  input word was all zeros.
- o_ERR  output  1  i_LZC inconsistent with i_WORD.
- o_VALID  output  1  output fields valid.
- i_READY  input  1  downstream accepts output.

## Operation
- Transfer rules: input transfer when i_VALID & o_READY; output transfer when o_VALID & i_READY.
- Stage 1 (coarse), loaded on input transfer:
  - s1_word = i_WORD << (8 * i_LZC[5:3]);
  - s1_fine = i_LZC[2:0];
  - s1_zero = (i_WORD == 0);
  - s1_bad = (i_LZC > 64);
  - s1_lzc = i_LZC;
  - s1_valid set.
- Stage 2 (fine), loaded when stage 1 holds data and stage 2 can accept:
  - o_NORM = s1_word << s1_fine;
  - o_ZERO = s1_zero;
  - o_EXP = s1_zero ? 0 : 63 - s1_lzc (7-bit, no wrap for legal counts).
- Error check in stage 2:
  - o_ERR = s1_bad, OR (s1_zero and s1_lzc != 64), OR (!s1_zero and result MSB != 1), OR (!s1_zero and any bit of the original word above its MSB is lost). The last case reduces to: the shift by s1_lzc removed a 1, detected as the popcount-free check "original word >> (64 - s1_lzc) != 0" for s1_lzc in 1..63.
  - For zero words with i_LZC == 64: o_NORM = 0, o_EXP = 0, o_ZERO = 1, o_ERR = 0.
  - i_LZC == 64 with a nonzero word sets o_ERR; o_NORM = 0 (full shift-out).
- Flow control (per-stage valid, no bubbles at full throughput):
  - s2_ready = !o_VALID | i_READY;
  - o_READY = !s1_valid | s2_ready (combinational path from i_READY to o_READY is permitted).
  - Stage 2 loads when s1_valid & s2_ready; s1_valid clears on that load unless an input transfer refills it in the same cycle.
  - o_VALID clears on output transfer unless stage 2 reloads in the same cycle.
- A stalled stage holds all of its fields stable. While o_VALID & !i_READY, every output is constant.
- Errored results flow through the pipeline like normal results; o_ERR is per-result, not sticky.

## Timing
- Reset (i_RST high at an edge) clears s1_valid, o_VALID, o_NORM, o_EXP, o_ZERO, o_ERR and all stage-1 registers to 0.
- o_READY = 1 in the cycle after reset.
- Reset mid-operation discards both in-flight results, with no output transfer.
- Latency: input accepted at edge N appears on outputs after edge N+1, i.e. o_VALID high in the cycle after two edges; two-cycle latency.
- Throughput: one result per cycle while i_READY is held high.
- Capacity: two results in flight. When both stages are full and i_READY = 0, o_READY = 0.
- Simultaneous events:
  - Input accept and stage-2 load in the same cycle are both legal.
  - Output take and stage-2 reload in the same cycle are both legal.

## Test plan
- i_WORD = 64'h0000A40100000001, i_LZC = 16, i_READY = 1 -> two cycles later o_NORM = 64'hA401000000010000, o_EXP = 47, o_ZERO = 0, o_ERR = 0.
- Back-to-back stream of i_WORD = 1 << k for k = 63..0 with i_LZC = 63-k -> one output per cycle; every o_NORM = 64'h8000000000000000; o_EXP = k.
- i_WORD = 0, i_LZC = 64 -> o_ZERO = 1, o_EXP = 0, o_NORM = 0, o_ERR = 0. Same word with i_LZC = 5 -> o_ERR = 1.
- i_WORD = 64'h00F0000000000000, i_LZC = 7 (should be 8) -> o_ERR = 1. Same word with i_LZC = 9 -> o_ERR = 1 (a 1 is shifted out).
- i_READY = 0 with three inputs offered -> two accepted, o_READY = 0 on the third. Outputs stay stable while stalled. Raising i_READY drains the results in order with no loss or duplication.
- i_RST asserted with both stages full -> o_VALID = 0 and o_READY = 1 on the next cycle; no stale result ever appears.

Source files
------------

// File: rtl/normalize_64_if.sv
// rtl/normalize_64_if.sv - handshake bundle between normalize_64 and its neighbours
// master drives the word/count and accepts results; slave is the normalizer itself.
interface normalize_64_if;
  logic [63:0] i_WORD;
  logic [6:0]  i_LZC;
  logic        i_VALID;
  logic        o_READY;
  logic [63:0] o_NORM;
  logic [6:0]  o_EXP;
  logic        o_ZERO;
  logic        o_ERR;
  logic        o_VALID;
  logic        i_READY;

  modport master (
    output i_WORD, i_LZC, i_VALID, i_READY,
    input  o_READY, o_NORM, o_EXP, o_ZERO, o_ERR, o_VALID
  );

  modport slave (
    input  i_WORD, i_LZC, i_VALID, i_READY,
    output o_READY, o_NORM, o_EXP, o_ZERO, o_ERR, o_VALID
  );
endinterface

// File: rtl/normalize_64.sv
// rtl/normalize_64.sv - two-stage left normalizer with leading-zero count cross-check
// Stage 1 does the byte-granular shift, stage 2 the bit shift plus error/exponent.
module normalize_64 (
  input  logic           i_CLK,
  input  logic           i_RST,
  normalize_64_if.slave  io_nrm
);
  localparam logic [63:0] ALL_ONES = {64{1'b1}};

  logic        r_s1_valid;
  logic [63:0] r_s1_word;
  logic [2:0]  r_s1_fine;
  logic        r_s1_zero;
  logic        r_s1_bad;
  logic        r_s1_lost;
  logic [6:0]  r_s1_lzc;

  logic        r_valid;
  logic [63:0] r_norm;
  logic [6:0]  r_exp;
  logic        r_zero;
  logic        r_err;

  logic        w_s2_ready;
  logic        w_in_xfer;
  logic        w_s2_load;
  logic [63:0] w_coarse;
  logic [63:0] w_lost_mask;
  logic [63:0] w_fine;
  logic        w_err;

  assign w_s2_ready     = !r_valid | io_nrm.i_READY;
  assign io_nrm.o_READY = !r_s1_valid | w_s2_ready;
  assign w_in_xfer      = io_nrm.i_VALID & io_nrm.o_READY;
  assign w_s2_load      = r_s1_valid & w_s2_ready;

  // A count of 64 or more shifts everything out, so bit 6 forces a zero word.
  assign w_coarse    = io_nrm.i_LZC[6] ? '0 : (io_nrm.i_WORD << {io_nrm.i_LZC[5:3], 3'b000});
  // Mask of the bits the full shift discards; any 1 there means the count was too large.
  assign w_lost_mask = io_nrm.i_LZC[6] ? ALL_ONES : ~(ALL_ONES >> io_nrm.i_LZC[5:0]);

  assign w_fine = r_s1_word << r_s1_fine;
  assign w_err  = r_s1_bad
                | (r_s1_zero & (r_s1_lzc != 7'd64))
                | (!r_s1_zero & (!w_fine[63] | r_s1_lost));

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_s1_valid <= 1'b0;
      r_s1_word  <= '0;
      r_s1_fine  <= '0;
      r_s1_zero  <= 1'b0;
      r_s1_bad   <= 1'b0;
      r_s1_lost  <= 1'b0;
      r_s1_lzc   <= '0;
    end else begin
      if (w_in_xfer) begin
        r_s1_valid <= 1'b1;
        r_s1_word  <= w_coarse;
        r_s1_fine  <= io_nrm.i_LZC[2:0];
        r_s1_zero  <= (io_nrm.i_WORD == 64'd0);
        r_s1_bad   <= (io_nrm.i_LZC > 7'd64);
        r_s1_lost  <= |(io_nrm.i_WORD & w_lost_mask);
        r_s1_lzc   <= io_nrm.i_LZC;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_valid <= 1'b0;
      r_norm  <= '0;
      r_exp   <= '0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_valid <= 1'b1;
        r_norm  <= w_fine;
        r_exp   <= r_s1_zero ? 7'd0 : (7'd63 - r_s1_lzc);
        r_zero  <= r_s1_zero;
        r_err   <= w_err;
      end else if (io_nrm.i_READY) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign io_nrm.o_VALID = r_valid;
  assign io_nrm.o_NORM  = r_norm;
  assign io_nrm.o_EXP   = r_exp;
  assign io_nrm.o_ZERO  = r_zero;
  assign io_nrm.o_ERR   = r_err;
endmodule

// File: tb/tb_normalize_64.sv
// tb/tb_normalize_64.sv - directed self-checking bench for normalize_64
module tb_normalize_64;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  normalize_64_if nrm ();

  normalize_64 dut (
    .i_CLK  (clk),
    .i_RST  (rst),
    .io_nrm (nrm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [63:0] w, input logic [6:0] l,
                         output logic [63:0] n, output logic [6:0] e,
                         output logic z, output logic er, output logic ok);
    ok = 1'b0;
    n = '0; e = '0; z = 1'b0; er = 1'b0;
    nrm.i_WORD  = w;
    nrm.i_LZC   = l;
    nrm.i_VALID = 1'b1;
    nrm.i_READY = 1'b1;
    tick();
    nrm.i_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (nrm.o_VALID) begin
        n = nrm.o_NORM; e = nrm.o_EXP; z = nrm.o_ZERO; er = nrm.o_ERR;
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nrm.i_VALID = 1'b0;
    nrm.i_READY = 1'b1;
    nrm.i_WORD  = '0;
    nrm.i_LZC   = '0;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if (nrm.o_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", nrm.o_VALID); end
    n_checks++;
    if (nrm.o_READY !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", nrm.o_READY); end
    n_checks++;
    if ({nrm.o_NORM, nrm.o_EXP, nrm.o_ZERO, nrm.o_ERR} !== 73'd0) begin
      n_fail++; $display("FAIL reset_fields: norm %h exp %0d zero %b err %b want all 0",
                         nrm.o_NORM, nrm.o_EXP, nrm.o_ZERO, nrm.o_ERR);
    end
  endtask

  task automatic test_basic();
    nrm.i_WORD  = 64'h0000A40100000001;
    nrm.i_LZC   = 7'd16;
    nrm.i_VALID = 1'b1;
    nrm.i_READY = 1'b1;
    tick();
    nrm.i_VALID = 1'b0;
    n_checks++;
    if (nrm.o_VALID !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: valid %b want 0 after one edge", nrm.o_VALID); end
    tick();
    n_checks++;
    if (nrm.o_VALID !== 1'b1) begin n_fail++; $display("FAIL basic_latency2: valid %b want 1 after two edges", nrm.o_VALID); end
    n_checks++;
    if (nrm.o_NORM !== 64'hA401000000010000 || nrm.o_EXP !== 7'd47 || nrm.o_ZERO !== 1'b0 || nrm.o_ERR !== 1'b0) begin
      n_fail++; $display("FAIL basic_result: norm %h exp %0d zero %b err %b want a401000000010000 47 0 0",
                         nrm.o_NORM, nrm.o_EXP, nrm.o_ZERO, nrm.o_ERR);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int got;
    int first_cyc;
    int cyc;
    int k;
    got = 0; first_cyc = -1; cyc = 0; k = 63;
    nrm.i_READY = 1'b1;
    nrm.i_WORD  = 64'd1 << k;
    nrm.i_LZC   = 7'(63 - k);
    nrm.i_VALID = 1'b1;
    while (cyc < 80 && got < 64) begin
      n_checks++;
      if (nrm.i_VALID && nrm.o_READY !== 1'b1) begin n_fail++; $display("FAIL stream_ready: cycle %0d ready %b want 1", cyc, nrm.o_READY); end
      tick();
      cyc++;
      if (nrm.o_VALID) begin
        if (first_cyc < 0) first_cyc = cyc;
        n_checks++;
        if (nrm.o_NORM !== 64'h8000000000000000 || nrm.o_EXP !== 7'(63 - got) || nrm.o_ERR !== 1'b0 || cyc != first_cyc + got) begin
          n_fail++; $display("FAIL stream_out%0d: norm %h exp %0d err %b cycle %0d want 8000000000000000 %0d 0 cycle %0d",
                             got, nrm.o_NORM, nrm.o_EXP, nrm.o_ERR, cyc, 63 - got, first_cyc + got);
        end
        got++;
      end
      if (k > 0) begin
        k--;
        nrm.i_WORD = 64'd1 << k;
        nrm.i_LZC  = 7'(63 - k);
      end else begin
        nrm.i_VALID = 1'b0;
      end
    end
    nrm.i_VALID = 1'b0;
    n_checks++;
    if (got != 64) begin n_fail++; $display("FAIL stream_count: got %0d results want 64", got); end
    tick();
  endtask

  task automatic test_zero();
    logic [63:0] n; logic [6:0] e; logic z, er, ok;
    run_one(64'd0, 7'd64, n, e, z, er, ok);
    n_checks++;
    if (!ok || n !== 64'd0 || e !== 7'd0 || z !== 1'b1 || er !== 1'b0) begin
      n_fail++; $display("FAIL zero_legal: ok %b norm %h exp %0d zero %b err %b want 1 0 0 1 0", ok, n, e, z, er);
    end
    run_one(64'd0, 7'd5, n, e, z, er, ok);
    n_checks++;
    if (!ok || z !== 1'b1 || er !== 1'b1 || e !== 7'd0) begin
      n_fail++; $display("FAIL zero_badcount: ok %b zero %b err %b exp %0d want 1 1 1 0", ok, z, er, e);
    end
  endtask

  task automatic test_errors();
    logic [63:0] n; logic [6:0] e; logic z, er, ok;
    run_one(64'h00F0000000000000, 7'd8, n, e, z, er, ok);
    n_checks++;
    if (!ok || n !== 64'hF000000000000000 || e !== 7'd55 || er !== 1'b0) begin
      n_fail++; $display("FAIL err_good8: ok %b norm %h exp %0d err %b want 1 f000000000000000 55 0", ok, n, e, er);
    end
    run_one(64'h00F0000000000000, 7'd7, n, e, z, er, ok);
    n_checks++;
    if (!ok || er !== 1'b1 || n !== 64'h7800000000000000) begin
      n_fail++; $display("FAIL err_short7: ok %b err %b norm %h want 1 1 7800000000000000", ok, er, n);
    end
    run_one(64'h00F0000000000000, 7'd9, n, e, z, er, ok);
    n_checks++;
    if (!ok || er !== 1'b1) begin n_fail++; $display("FAIL err_long9: ok %b err %b want 1 1", ok, er); end
    run_one(64'h0000000000000001, 7'd64, n, e, z, er, ok);
    n_checks++;
    if (!ok || er !== 1'b1 || n !== 64'd0 || z !== 1'b0) begin
      n_fail++; $display("FAIL err_lzc64: ok %b err %b norm %h zero %b want 1 1 0 0", ok, er, n, z);
    end
    run_one(64'd0, 7'd65, n, e, z, er, ok);
    n_checks++;
    if (!ok || er !== 1'b1) begin n_fail++; $display("FAIL err_lzc65: ok %b err %b want 1 1", ok, er); end
    run_one(64'h8000000000000000, 7'd0, n, e, z, er, ok);
    n_checks++;
    if (!ok || er !== 1'b0 || n !== 64'h8000000000000000 || e !== 7'd63) begin
      n_fail++; $display("FAIL err_lzc0: ok %b err %b norm %h exp %0d want 1 0 8000000000000000 63", ok, er, n, e);
    end
  endtask

  task automatic test_stall();
    nrm.i_READY = 1'b0;
    nrm.i_WORD  = 64'h1;  nrm.i_LZC = 7'd63; nrm.i_VALID = 1'b1;
    n_checks++;
    if (nrm.o_READY !== 1'b1) begin n_fail++; $display("FAIL stall_acceptA: ready %b want 1", nrm.o_READY); end
    tick();
    nrm.i_WORD  = 64'h3;  nrm.i_LZC = 7'd62;
    n_checks++;
    if (nrm.o_READY !== 1'b1) begin n_fail++; $display("FAIL stall_acceptB: ready %b want 1", nrm.o_READY); end
    tick();
    nrm.i_WORD  = 64'hFF; nrm.i_LZC = 7'd56;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (nrm.o_READY !== 1'b0 || nrm.o_VALID !== 1'b1 || nrm.o_NORM !== 64'h8000000000000000 || nrm.o_EXP !== 7'd0) begin
        n_fail++; $display("FAIL stall_hold%0d: ready %b valid %b norm %h exp %0d want 0 1 8000000000000000 0",
                           i, nrm.o_READY, nrm.o_VALID, nrm.o_NORM, nrm.o_EXP);
      end
      tick();
    end
    nrm.i_READY = 1'b1;
    #1;
    n_checks++;
    if (nrm.o_READY !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: ready %b want 1", nrm.o_READY); end
    tick();
    nrm.i_VALID = 1'b0;
    n_checks++;
    if (nrm.o_VALID !== 1'b1 || nrm.o_NORM !== 64'hC000000000000000 || nrm.o_EXP !== 7'd1) begin
      n_fail++; $display("FAIL stall_drainB: valid %b norm %h exp %0d want 1 c000000000000000 1", nrm.o_VALID, nrm.o_NORM, nrm.o_EXP);
    end
    tick();
    n_checks++;
    if (nrm.o_VALID !== 1'b1 || nrm.o_NORM !== 64'hFF00000000000000 || nrm.o_EXP !== 7'd7) begin
      n_fail++; $display("FAIL stall_drainC: valid %b norm %h exp %0d want 1 ff00000000000000 7", nrm.o_VALID, nrm.o_NORM, nrm.o_EXP);
    end
    tick();
    n_checks++;
    if (nrm.o_VALID !== 1'b0) begin n_fail++; $display("FAIL stall_empty: valid %b want 0 (duplicate)", nrm.o_VALID); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] n; logic [6:0] e; logic z, er, ok;
    int seen;
    nrm.i_READY = 1'b0;
    nrm.i_VALID = 1'b1;
    nrm.i_WORD  = 64'h10; nrm.i_LZC = 7'd59;
    tick();
    nrm.i_WORD  = 64'h20; nrm.i_LZC = 7'd58;
    tick();
    nrm.i_VALID = 1'b0;
    n_checks++;
    if (nrm.o_READY !== 1'b0 || nrm.o_VALID !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_full: ready %b valid %b want 0 1", nrm.o_READY, nrm.o_VALID);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (nrm.o_VALID !== 1'b0 || nrm.o_READY !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_after: valid %b ready %b want 0 1", nrm.o_VALID, nrm.o_READY);
    end
    nrm.i_READY = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (nrm.o_VALID) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL rstmid_stale: %0d stale results want 0", seen); end
    run_one(64'h0000000000000100, 7'd55, n, e, z, er, ok);
    n_checks++;
    if (!ok || n !== 64'h8000000000000000 || e !== 7'd8 || er !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_recover: ok %b norm %h exp %0d err %b want 1 8000000000000000 8 0", ok, n, e, er);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero();
    test_errors();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
